// File: rtl/bids22_round_sequencer.sv
// Sequences bids22 engine control (C_op/C_data/C_start) from a valid/ready command stream and
// returns one response per command. Optional round/timeout statistics: define BIDS22_SEQ_STATS_EN.
module bids22_round_sequencer #(
    parameter int DATAWIDTH = 32,
    parameter int OPWIDTH   = 4,
    parameter int LENWIDTH  = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    // Command and response channels: a transfer happens on a clock edge where valid and ready
    // are both high; the producer holds valid and its payload stable until that edge.
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_round,
    input  logic [OPWIDTH-1:0]   cmd_op,
    input  logic [DATAWIDTH-1:0] cmd_data,
    input  logic [LENWIDTH-1:0]  cmd_len,
    output logic [OPWIDTH-1:0]   C_op,
    output logic [DATAWIDTH-1:0] C_data,
    output logic                 C_start,
    input  logic                 ready,
    input  logic [2:0]           err,
    input  logic                 roundOver,
    input  logic [DATAWIDTH-1:0] maxBid,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_err,
    output logic                 rsp_timeout,
    output logic [DATAWIDTH-1:0] rsp_data,
    output logic                 busy,
    output logic [2:0]           o_dbg_state
`ifdef BIDS22_SEQ_STATS_EN
    ,
    output logic [15:0]          rounds_done,
    output logic [7:0]           timeouts
`endif
);

    localparam logic [OPWIDTH-1:0]  NO_OP    = '0;
    localparam int                  TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]       TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]       TMO_ONE  = TW'(1);
    localparam logic [LENWIDTH-1:0] LEN_ONE  = LENWIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAITRDY = 3'd2,
        S_RUN     = 3'd3,
        S_WAITOVR = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [OPWIDTH-1:0]    r_op;
    logic [DATAWIDTH-1:0]  r_data;
    logic [LENWIDTH-1:0]   r_len_cmd;
    logic [LENWIDTH-1:0]   r_len;
    logic [TW-1:0]         r_tmo;
    logic                  w_tmo_hit;
    logic                  w_round_ok;
    logic                  w_timeout;
    logic [LENWIDTH-1:0]   w_len_load;

    assign w_tmo_hit  = (r_tmo == TMO_LAST);
    assign w_round_ok = (r_state == S_WAITOVR) && roundOver;
    assign w_timeout  = w_tmo_hit &&
                        (((r_state == S_WAITRDY) && !ready) ||
                         ((r_state == S_WAITOVR) && !roundOver));
    // A zero-length round still pulses C_start for one cycle.
    assign w_len_load = (r_len_cmd == '0) ? LEN_ONE : r_len_cmd;

    // Engine-facing outputs decode from state and latched fields only.
    assign cmd_ready   = (r_state == S_IDLE) && !reset;
    assign busy        = (r_state != S_IDLE);
    assign C_op        = (r_state == S_ISSUE) ? r_op : NO_OP;
    assign C_data      = (r_state == S_ISSUE) ? r_data : '0;
    assign C_start     = (r_state == S_RUN);
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_next = cmd_round ? S_WAITRDY : S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_RESP;
            S_WAITRDY: begin
                if (ready) begin
                    w_next = S_RUN;
                end else if (w_tmo_hit) begin
                    w_next = S_RESP;
                end
            end
            S_RUN: begin
                if (r_len <= LEN_ONE) begin
                    w_next = S_WAITOVR;
                end
            end
            S_WAITOVR: begin
                if (roundOver || w_tmo_hit) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op        <= NO_OP;
            r_data      <= '0;
            r_len_cmd   <= '0;
            r_len       <= '0;
            r_tmo       <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 3'd0;
            rsp_timeout <= 1'b0;
            rsp_data    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tmo <= '0;
                    if (cmd_valid) begin
                        r_op      <= cmd_op;
                        r_data    <= cmd_data;
                        r_len_cmd <= cmd_len;
                    end
                end
                S_ISSUE: begin
                    // err is combinational on C_op, so it is valid in this cycle only.
                    rsp_valid   <= 1'b1;
                    rsp_err     <= err;
                    rsp_timeout <= 1'b0;
                    rsp_data    <= '0;
                end
                S_WAITRDY: begin
                    if (ready) begin
                        r_len <= w_len_load;
                        r_tmo <= '0;
                    end else if (w_tmo_hit) begin
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 3'd0;
                        rsp_timeout <= 1'b1;
                        rsp_data    <= '0;
                    end else if (r_tmo != '1) begin
                        r_tmo <= r_tmo + TMO_ONE;
                    end
                end
                S_RUN: begin
                    r_tmo <= '0;
                    if (r_len > LEN_ONE) begin
                        r_len <= r_len - LEN_ONE;
                    end
                end
                S_WAITOVR: begin
                    if (roundOver) begin
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 3'd0;
                        rsp_timeout <= 1'b0;
                        rsp_data    <= maxBid;
                    end else if (w_tmo_hit) begin
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 3'd0;
                        rsp_timeout <= 1'b1;
                        rsp_data    <= '0;
                    end else if (r_tmo != '1) begin
                        r_tmo <= r_tmo + TMO_ONE;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_err     <= 3'd0;
                        rsp_timeout <= 1'b0;
                        rsp_data    <= '0;
                    end
                end
                default: begin
                    r_tmo <= '0;
                end
            endcase
        end
    end

`ifdef BIDS22_SEQ_STATS_EN
    logic [15:0] r_rounds_done;
    logic [7:0]  r_timeouts;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rounds_done <= 16'd0;
            r_timeouts    <= 8'd0;
        end else begin
            if (w_round_ok && (r_rounds_done != 16'hFFFF)) begin
                r_rounds_done <= r_rounds_done + 16'd1;
            end
            if (w_timeout && (r_timeouts != 8'hFF)) begin
                r_timeouts <= r_timeouts + 8'd1;
            end
        end
    end

    assign rounds_done = r_rounds_done;
    assign timeouts    = r_timeouts;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_round_ok ^ w_timeout;
`endif

endmodule

// File: tb/tb_bids22_round_sequencer.sv
// Directed bench for bids22_round_sequencer: config issue, round sequencing, timeouts,
// mid-round reset and back-to-back throughput.
module tb_bids22_round_sequencer;

    localparam logic [3:0] OP_LOADX  = 4'd2;
    localparam logic [3:0] OP_UNLOCK = 4'd5;
    localparam logic [2:0] ERR_ALREADYUNLOCKED = 3'd3;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_round;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_data;
    logic [15:0] cmd_len;
    logic [3:0]  C_op;
    logic [31:0] C_data;
    logic        C_start;
    logic        ready;
    logic [2:0]  err;
    logic        roundOver;
    logic [31:0] maxBid;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_err;
    logic        rsp_timeout;
    logic [31:0] rsp_data;
    logic        busy;
    logic [2:0]  dbg_state;
`ifdef BIDS22_SEQ_STATS_EN
    logic [15:0] rounds_done;
    logic [7:0]  timeouts;
`endif

    int checks   = 0;
    int failures = 0;

    bids22_round_sequencer #(
        .DATAWIDTH(32), .OPWIDTH(4), .LENWIDTH(16), .TIMEOUT(64)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_round(cmd_round),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
        .C_op(C_op), .C_data(C_data), .C_start(C_start),
        .ready(ready), .err(err), .roundOver(roundOver), .maxBid(maxBid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .rsp_data(rsp_data), .busy(busy),
        .o_dbg_state(dbg_state)
`ifdef BIDS22_SEQ_STATS_EN
        , .rounds_done(rounds_done), .timeouts(timeouts)
`endif
    );

    // Engine err is combinational on C_op: UNLOCK reports ALREADYUNLOCKED.
    assign err = (C_op == OP_UNLOCK) ? ERR_ALREADYUNLOCKED : 3'd0;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_config(input logic [3:0] op, input logic [31:0] data);
        cmd_round = 1'b0;
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic run_round(input logic [15:0] len, input int ovr_delay,
                             input logic [31:0] bid, output int high_cnt);
        high_cnt  = 0;
        cmd_round = 1'b1;
        cmd_len   = len;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (C_start) high_cnt++;
            else if (high_cnt > 0) break;
            tick();
        end
        repeat (ovr_delay) tick();
        roundOver = 1'b1;
        maxBid    = bid;
        tick();
        roundOver = 1'b0;
        maxBid    = 32'd0;
        for (int i = 0; i < 200 && !rsp_valid; i++) tick();
    endtask

    // Tests
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || C_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: cmd_ready=%b busy=%b rsp_valid=%b C_start=%b required all 0",
                     cmd_ready, busy, rsp_valid, C_start);
        end
        checks++;
        if (C_op !== 4'd0 || C_data !== 32'd0 || rsp_data !== 32'd0 || rsp_err !== 3'd0 || rsp_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: C_op=%0d C_data=%0d rsp_data=%0d rsp_err=%0d rsp_timeout=%b required 0",
                     C_op, C_data, rsp_data, rsp_err, rsp_timeout);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || dbg_state !== 3'd0) begin
            failures++;
            $display("FAIL reset_idle: cmd_ready=%b state=%0d required 1/0", cmd_ready, dbg_state);
        end
    endtask

    task automatic test_config_loadx();
        send_config(OP_LOADX, 32'd100);
        checks++;
        if (C_op !== OP_LOADX || C_data !== 32'd100 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL loadx_issue: C_op=%0d C_data=%0d cmd_ready=%b busy=%b required %0d/100/0/1",
                     C_op, C_data, cmd_ready, busy, OP_LOADX);
        end
        tick();
        checks++;
        if (C_op !== 4'd0 || C_data !== 32'd0) begin
            failures++;
            $display("FAIL loadx_release: C_op=%0d C_data=%0d required 0/0", C_op, C_data);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 3'd0 || rsp_data !== 32'd0 || rsp_timeout !== 1'b0) begin
            failures++;
            $display("FAIL loadx_rsp: valid=%b err=%0d data=%0d timeout=%b required 1/0/0/0",
                     rsp_valid, rsp_err, rsp_data, rsp_timeout);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL loadx_hold: rsp_valid=%b cmd_ready=%b required 1/0", rsp_valid, cmd_ready);
        end
        handshake();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL loadx_done: rsp_valid=%b cmd_ready=%b busy=%b required 0/1/0",
                     rsp_valid, cmd_ready, busy);
        end
    endtask

    task automatic test_config_unlock();
        send_config(OP_UNLOCK, 32'd7);
        checks++;
        if (C_op !== OP_UNLOCK) begin
            failures++;
            $display("FAIL unlock_issue: C_op=%0d required %0d", C_op, OP_UNLOCK);
        end
        tick();
        checks++;
        if (C_op !== 4'd0 || rsp_valid !== 1'b1 || rsp_err !== ERR_ALREADYUNLOCKED) begin
            failures++;
            $display("FAIL unlock_rsp: C_op=%0d rsp_valid=%b rsp_err=%0d required 0/1/%0d",
                     C_op, rsp_valid, rsp_err, ERR_ALREADYUNLOCKED);
        end
        handshake();
    endtask

    task automatic test_round_len5();
        int hc;
        ready = 1'b1;
        run_round(16'd5, 2, 32'd42, hc);
        checks++;
        if (hc != 5) begin
            failures++;
            $display("FAIL round5_start_len: C_start high %0d cycles required 5", hc);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd42 || rsp_timeout !== 1'b0 || rsp_err !== 3'd0) begin
            failures++;
            $display("FAIL round5_rsp: valid=%b data=%0d timeout=%b err=%0d required 1/42/0/0",
                     rsp_valid, rsp_data, rsp_timeout, rsp_err);
        end
        handshake();
    endtask

    task automatic test_round_len0();
        int hc;
        ready = 1'b1;
        run_round(16'd0, 0, 32'h0BAD_F00D, hc);
        checks++;
        if (hc != 1) begin
            failures++;
            $display("FAIL round0_start_len: C_start high %0d cycles required 1", hc);
        end
        checks++;
        if (rsp_data !== 32'h0BAD_F00D || rsp_timeout !== 1'b0) begin
            failures++;
            $display("FAIL round0_rsp: data=%h timeout=%b required 0badf00d/0", rsp_data, rsp_timeout);
        end
        handshake();
    endtask

    task automatic test_ready_timeout();
        int  cyc;
        logic saw_start;
        ready     = 1'b0;
        saw_start = 1'b0;
        cyc       = 0;
        cmd_round = 1'b1;
        cmd_len   = 16'd3;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 200 && !rsp_valid; i++) begin
            if (C_start) saw_start = 1'b1;
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 64) begin
            failures++;
            $display("FAIL ready_tmo_latency: response after %0d cycles required 64", cyc);
        end
        checks++;
        if (saw_start !== 1'b0 || rsp_timeout !== 1'b1 || rsp_data !== 32'd0) begin
            failures++;
            $display("FAIL ready_tmo_rsp: saw_start=%b timeout=%b data=%0d required 0/1/0",
                     saw_start, rsp_timeout, rsp_data);
        end
        handshake();
        ready = 1'b1;
    endtask

    task automatic test_over_timeout();
        int hc;
        int cyc;
        hc        = 0;
        cyc       = 0;
        ready     = 1'b1;
        cmd_round = 1'b1;
        cmd_len   = 16'd2;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (C_start) hc++;
            else if (hc > 0) break;
            tick();
        end
        for (int i = 0; i < 200 && !rsp_valid; i++) begin
            tick();
            cyc++;
        end
        checks++;
        if (hc != 2 || cyc != 64) begin
            failures++;
            $display("FAIL over_tmo: start_cycles=%0d wait=%0d required 2/64", hc, cyc);
        end
        checks++;
        if (rsp_timeout !== 1'b1 || rsp_data !== 32'd0) begin
            failures++;
            $display("FAIL over_tmo_rsp: timeout=%b data=%0d required 1/0", rsp_timeout, rsp_data);
        end
        handshake();
    endtask

    task automatic test_reset_mid_run();
        ready     = 1'b1;
        cmd_round = 1'b1;
        cmd_len   = 16'd10;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if (C_start !== 1'b1) begin
            failures++;
            $display("FAIL midrun_start: C_start=%b required 1", C_start);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (C_start !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset: C_start=%b busy=%b rsp_valid=%b required 0/0/0",
                     C_start, busy, rsp_valid);
        end
`ifdef BIDS22_SEQ_STATS_EN
        checks++;
        if (rounds_done !== 16'd0 || timeouts !== 8'd0) begin
            failures++;
            $display("FAIL midrun_stats: rounds_done=%0d timeouts=%0d required 0/0", rounds_done, timeouts);
        end
`endif
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrun_ready: cmd_ready=%b required 1", cmd_ready);
        end
        send_config(OP_LOADX, 32'd55);
        checks++;
        if (C_op !== OP_LOADX || C_data !== 32'd55) begin
            failures++;
            $display("FAIL midrun_next: C_op=%0d C_data=%0d required %0d/55", C_op, C_data, OP_LOADX);
        end
        tick();
        handshake();
    endtask

    task automatic test_back_to_back();
        int acc;
        int rsp_cnt;
        acc       = 0;
        rsp_cnt   = 0;
        rsp_ready = 1'b1;
        cmd_round = 1'b0;
        cmd_op    = OP_LOADX;
        cmd_data  = 32'd9;
        cmd_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (cmd_ready) acc++;
            if (rsp_valid) rsp_cnt++;
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        checks++;
        if (acc != 4 || rsp_cnt != 4) begin
            failures++;
            $display("FAIL back_to_back: accepts=%0d responses=%0d in 12 cycles required 4/4", acc, rsp_cnt);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_idle: busy=%b rsp_valid=%b required 0/0", busy, rsp_valid);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_round = 1'b0;
        cmd_op    = 4'd0;
        cmd_data  = 32'd0;
        cmd_len   = 16'd0;
        ready     = 1'b0;
        roundOver = 1'b0;
        maxBid    = 32'd0;
        rsp_ready = 1'b0;

        test_reset();
        test_config_loadx();
        test_config_unlock();
        test_round_len5();
        test_round_len0();
        test_ready_timeout();
        test_over_timeout();
        test_reset_mid_run();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
